// File: rtl/mem_request_arbiter_pkg.sv
// Shared constants for the memory request arbiter: field widths, bank codes,
// and initiator IDs.
package mem_request_arbiter_pkg;

  localparam int unsigned BANK_W = 4;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;

  localparam logic [BANK_W-1:0] BANK_SDRAM    = 4'd0;
  localparam logic [BANK_W-1:0] BANK_CART     = 4'd1;
  localparam logic [BANK_W-1:0] BANK_FLASHRAM = 4'd2;

  typedef enum logic {
    INIT_A = 1'b0,
    INIT_B = 1'b1
  } init_id_e;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Bundle of both initiator request ports and the downstream SDRAM port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_request_arbiter_if;
  import mem_request_arbiter_pkg::*;

  logic              i_req_a;
  logic              i_write_a;
  logic [BANK_W-1:0] i_bank_a;
  logic [ADDR_W-1:0] i_address_a;
  logic [DATA_W-1:0] i_data_a;
  logic              o_busy_a;
  logic              o_ack_a;
  logic [DATA_W-1:0] o_data_a;

  logic              i_req_b;
  logic              i_write_b;
  logic [BANK_W-1:0] i_bank_b;
  logic [ADDR_W-1:0] i_address_b;
  logic [DATA_W-1:0] i_data_b;
  logic              o_busy_b;
  logic              o_ack_b;
  logic [DATA_W-1:0] o_data_b;

  logic              o_mem_request;
  logic              o_mem_write;
  logic [BANK_W-1:0] o_mem_bank;
  logic [ADDR_W-1:0] o_mem_address;
  logic [DATA_W-1:0] o_mem_data;
  logic              i_mem_busy;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_error;

  modport slave (
    input  i_req_a, i_write_a, i_bank_a, i_address_a, i_data_a,
    output o_busy_a, o_ack_a, o_data_a,
    input  i_req_b, i_write_b, i_bank_b, i_address_b, i_data_b,
    output o_busy_b, o_ack_b, o_data_b,
    output o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data,
    input  i_mem_busy, i_mem_ack, i_mem_data,
    output o_error
  );

  modport master (
    output i_req_a, i_write_a, i_bank_a, i_address_a, i_data_a,
    input  o_busy_a, o_ack_a, o_data_a,
    output i_req_b, i_write_b, i_bank_b, i_address_b, i_data_b,
    input  o_busy_b, o_ack_b, o_data_b,
    input  o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data,
    output i_mem_busy, i_mem_ack, i_mem_data,
    input  o_error
  );

endinterface

// File: rtl/mem_request_arbiter_tag_fifo.sv
// 1-bit wide tag FIFO recording which initiator issued each outstanding read.
// Pushes while full and pops while empty are ignored.
module mem_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push_i,
  input  logic                     din_i,
  input  logic                     pop_i,
  output logic                     head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    do_push = push_i && !full;
    do_pop  = pop_i && (count_q != '0);
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mem_request_arbiter.sv
// Two-initiator round-robin arbiter feeding a one-entry SDRAM request slot,
// with in-order read acks routed back to the issuing initiator.
module mem_request_arbiter #(
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mem_request_arbiter_if.slave bus
);
  import mem_request_arbiter_pkg::*;

  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  init_id_e          rr_q, rr_d, grant_id;
  logic              grant_valid, grant_write, slot_free, tag_ok, accept;
  logic              busy_a, busy_b;

  logic              req_q, req_d, write_q, write_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              ack_a_q, ack_b_q, error_q;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

  logic              tag_push, tag_head, tag_empty, pop_ok;
  logic [CNT_W-1:0]  tag_count;

  always_comb begin
    slot_free = !req_q || !bus.i_mem_busy;
    tag_ok    = tag_count < CNT_W'(TAG_DEPTH);

    grant_valid = bus.i_req_a || bus.i_req_b;
    if (bus.i_req_a && bus.i_req_b) grant_id = rr_q;
    else if (bus.i_req_b)           grant_id = INIT_B;
    else                            grant_id = INIT_A;
    grant_write = (grant_id == INIT_B) ? bus.i_write_b : bus.i_write_a;

    accept = grant_valid && slot_free && (grant_write || tag_ok);
    busy_a = !(grant_valid && grant_id == INIT_A) || !slot_free ||
             (!bus.i_write_a && !tag_ok);
    busy_b = !(grant_valid && grant_id == INIT_B) || !slot_free ||
             (!bus.i_write_b && !tag_ok);

    rr_d = rr_q;
    if (accept) rr_d = (grant_id == INIT_A) ? INIT_B : INIT_A;

    req_d   = req_q;
    write_d = write_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      req_d = 1'b1;
      if (grant_id == INIT_B) begin
        write_d = bus.i_write_b;
        bank_d  = bus.i_bank_b;
        addr_d  = bus.i_address_b;
        data_d  = bus.i_data_b;
      end else begin
        write_d = bus.i_write_a;
        bank_d  = bus.i_bank_a;
        addr_d  = bus.i_address_a;
        data_d  = bus.i_data_a;
      end
    end else if (!bus.i_mem_busy) begin
      req_d = 1'b0;
    end

    tag_push = accept && !grant_write;
    pop_ok   = bus.i_mem_ack && !tag_empty;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_q    <= INIT_A;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      bank_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      req_q   <= req_d;
      write_q <= write_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Ack return: head tag selects the destination; an ack with no tag is an error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      error_q   <= 1'b0;
    end else begin
      ack_a_q <= pop_ok && (tag_head == INIT_A);
      ack_b_q <= pop_ok && (tag_head == INIT_B);
      if (pop_ok && tag_head == INIT_A) rdata_a_q <= bus.i_mem_data;
      if (pop_ok && tag_head == INIT_B) rdata_b_q <= bus.i_mem_data;
      error_q <= error_q || (bus.i_mem_ack && tag_empty);
    end
  end

  mem_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push_i  (tag_push),
    .din_i   (grant_id),
    .pop_i   (bus.i_mem_ack),
    .head_o  (tag_head),
    .count_o (tag_count),
    .empty_o (tag_empty)
  );

  assign bus.o_busy_a      = busy_a;
  assign bus.o_busy_b      = busy_b;
  assign bus.o_ack_a       = ack_a_q;
  assign bus.o_ack_b       = ack_b_q;
  assign bus.o_data_a      = rdata_a_q;
  assign bus.o_data_b      = rdata_b_q;
  assign bus.o_mem_request = req_q;
  assign bus.o_mem_write   = write_q;
  assign bus.o_mem_bank    = bank_q;
  assign bus.o_mem_address = addr_q;
  assign bus.o_mem_data    = data_q;
  assign bus.o_error       = error_q;

endmodule
